// File: rtl/bp_me_pkg.sv
// bp_me_pkg
// Shared types for the lite memory arbiter slice:
//   arb_state_e : command-side FSM states (idle / header / data)
//   src_id_t    : identifies a requesting port (0 = I$, 1 = D$)
//   rr_pick     : round-robin choice between the two header valids
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_arb_idle = 2'd0,
    e_arb_hdr  = 2'd1,
    e_arb_data = 2'd2
  } arb_state_e;

  typedef logic [0:0] src_id_t;

  localparam int unsigned num_src_lp = 2;

  // The preferred source wins if it is requesting; otherwise the other one.
  function automatic src_id_t rr_pick(input logic [1:0] valid, input src_id_t prio);
    if (valid[prio]) return prio;
    return ~prio;
  endfunction

endpackage

// File: rtl/bp_lite_mem_tag_fifo.sv
// bp_lite_mem_tag_fifo
// In-order FIFO of 1-bit source tags, one entry per in-flight command.
// Ports:
//   clk_i, reset_i       : clock, asynchronous active-high reset (empties FIFO)
//   push_i, data_i       : enqueue a source tag (ignored when full)
//   pop_i                : dequeue the head tag (ignored when empty)
//   data_o               : head tag
//   full_o, empty_o      : occupancy flags
//   count_o              : number of stored tags
module bp_lite_mem_tag_fifo
  import bp_me_pkg::*;
  #(parameter int outstanding_p = 4)
  (input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            push_i,
   input  src_id_t                         data_i,
   input  logic                            pop_i,
   output src_id_t                         data_o,
   output logic                            full_o,
   output logic                            empty_o,
   output logic [$clog2(outstanding_p):0]  count_o);

  localparam int ptr_width_lp = $clog2(outstanding_p);
  localparam logic [ptr_width_lp:0] full_count_lp = (ptr_width_lp+1)'(outstanding_p);

  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [ptr_width_lp:0]   count_r;
  src_id_t                 mem_r [outstanding_p];
  logic                    push_ok, pop_ok;

  // A push is refused whenever the FIFO is full, even if a pop frees a slot
  // in the same cycle; the freed slot becomes usable on the next cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers are exactly log2(depth) bits wide, so they wrap on their own.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_r[wr_ptr_r] <= data_i;
  end

  assign data_o  = mem_r[rd_ptr_r];
  assign full_o  = (count_r == full_count_lp);
  assign empty_o = (count_r == '0);
  assign count_o = count_r;

endmodule

// File: rtl/bp_lite_mem_arbiter.sv
// bp_lite_mem_arbiter
// Merges the lite unicore's two UCE memory streams (port 0 = I$, port 1 = D$)
// onto one BedRock stream memory port. Grants are round-robin and held for a
// whole message; each issued command records its source in a tag FIFO, whose
// head steers the in-order response stream back to the right port.
// Ports:
//   clk_i, reset_i            : clock, asynchronous active-high reset
//   mem_cmd_*_i / *_o (x2)    : per-source command streams (packed, port 0 low)
//   mem_cmd_*  (single)       : merged command stream toward memory
//   mem_resp_* (single)       : response stream from memory
//   mem_resp_*_o / *_i (x2)   : per-source response streams
// Optional feature macro: BP_LITE_MEM_ARB_STATS_EN adds stat_cmd_o / stat_stall_o,
// per-source 32-bit saturating counts of issued commands and stalled header cycles.
// header_width_p is overridden by the parent with the BedRock mem header width.
module bp_lite_mem_arbiter
  import bp_me_pkg::*;
  #(parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int outstanding_p  = 4)
  (input  logic                        clk_i,
   input  logic                        reset_i,

   input  logic [2*header_width_p-1:0] mem_cmd_header_i,
   input  logic [1:0]                  mem_cmd_header_v_i,
   output logic [1:0]                  mem_cmd_header_ready_and_o,
   input  logic [1:0]                  mem_cmd_has_data_i,
   input  logic [2*data_width_p-1:0]   mem_cmd_data_i,
   input  logic [1:0]                  mem_cmd_data_v_i,
   output logic [1:0]                  mem_cmd_data_ready_and_o,
   input  logic [1:0]                  mem_cmd_last_i,

   output logic [header_width_p-1:0]   mem_cmd_header_o,
   output logic                        mem_cmd_header_v_o,
   input  logic                        mem_cmd_header_ready_and_i,
   output logic                        mem_cmd_has_data_o,
   output logic [data_width_p-1:0]     mem_cmd_data_o,
   output logic                        mem_cmd_data_v_o,
   input  logic                        mem_cmd_data_ready_and_i,
   output logic                        mem_cmd_last_o,

   input  logic [header_width_p-1:0]   mem_resp_header_i,
   input  logic                        mem_resp_header_v_i,
   output logic                        mem_resp_header_ready_and_o,
   input  logic                        mem_resp_has_data_i,
   input  logic [data_width_p-1:0]     mem_resp_data_i,
   input  logic                        mem_resp_data_v_i,
   output logic                        mem_resp_data_ready_and_o,
   input  logic                        mem_resp_last_i,

   output logic [2*header_width_p-1:0] mem_resp_header_o,
   output logic [1:0]                  mem_resp_header_v_o,
   input  logic [1:0]                  mem_resp_header_ready_and_i,
   output logic [1:0]                  mem_resp_has_data_o,
   output logic [2*data_width_p-1:0]   mem_resp_data_o,
   output logic [1:0]                  mem_resp_data_v_o,
   input  logic [1:0]                  mem_resp_data_ready_and_i,
   output logic [1:0]                  mem_resp_last_o
`ifdef BP_LITE_MEM_ARB_STATS_EN
   ,
   output logic [1:0][31:0]            stat_cmd_o,
   output logic [1:0][31:0]            stat_stall_o
`endif
   );

  arb_state_e state_r, state_n;
  src_id_t    grant_r, grant_n;
  src_id_t    prio_r, prio_n;
  src_id_t    cur_src;
  logic       hdr_phase, data_phase;
  logic       hdr_fire, data_fire;

  logic       fifo_full, fifo_empty, fifo_pop;
  src_id_t    fifo_head;
  logic       resp_active;
  logic [$clog2(outstanding_p):0] unused_fifo_count;

  // State register: grant and priority pointer live alongside the FSM state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_arb_idle;
      grant_r <= '0;
      prio_r  <= '0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      prio_r  <= prio_n;
    end
  end

  // Next-state logic. In idle the round-robin pick is presented to memory in
  // the same cycle, so the header can complete without a bubble; if it is not
  // accepted the pick is latched and held until it is.
  always_comb begin
    state_n    = state_r;
    grant_n    = grant_r;
    prio_n     = prio_r;
    cur_src    = grant_r;
    hdr_phase  = 1'b0;
    data_phase = 1'b0;

    case (state_r)
      e_arb_idle: begin
        if (~fifo_full && (|mem_cmd_header_v_i)) begin
          cur_src   = rr_pick(mem_cmd_header_v_i, prio_r);
          grant_n   = cur_src;
          hdr_phase = 1'b1;
          state_n   = e_arb_hdr;
        end
      end
      e_arb_hdr:  hdr_phase  = ~fifo_full;
      e_arb_data: data_phase = 1'b1;
      default:    state_n    = e_arb_idle;
    endcase

    // Outputs must fall as soon as reset is raised, before the flops clear.
    hdr_phase  = hdr_phase & ~reset_i;
    data_phase = data_phase & ~reset_i;

    hdr_fire  = hdr_phase & mem_cmd_header_v_i[cur_src] & mem_cmd_header_ready_and_i;
    data_fire = data_phase & mem_cmd_data_v_i[cur_src] & mem_cmd_data_ready_and_i;

    if (hdr_fire) begin
      prio_n  = ~cur_src;
      state_n = mem_cmd_has_data_i[cur_src] ? e_arb_data : e_arb_idle;
    end
    if (data_fire && mem_cmd_last_i[cur_src]) begin
      state_n = e_arb_idle;
    end
  end

  // Command-side muxing: only the granted source sees ready.
  always_comb begin
    mem_cmd_header_o   = cur_src[0] ? mem_cmd_header_i[2*header_width_p-1:header_width_p]
                                    : mem_cmd_header_i[header_width_p-1:0];
    mem_cmd_data_o     = cur_src[0] ? mem_cmd_data_i[2*data_width_p-1:data_width_p]
                                    : mem_cmd_data_i[data_width_p-1:0];
    mem_cmd_header_v_o = hdr_phase & mem_cmd_header_v_i[cur_src];
    mem_cmd_has_data_o = mem_cmd_has_data_i[cur_src];
    mem_cmd_data_v_o   = data_phase & mem_cmd_data_v_i[cur_src];
    mem_cmd_last_o     = mem_cmd_last_i[cur_src];

    mem_cmd_header_ready_and_o = '0;
    mem_cmd_data_ready_and_o   = '0;
    for (int i = 0; i < num_src_lp; i++) begin
      mem_cmd_header_ready_and_o[i] = hdr_phase  & (cur_src == src_id_t'(i)) & mem_cmd_header_ready_and_i;
      mem_cmd_data_ready_and_o[i]   = data_phase & (cur_src == src_id_t'(i)) & mem_cmd_data_ready_and_i;
    end
  end

  // Response steering: the oldest outstanding tag owns the response stream.
  // A response retires on its header when it has no data, else on its last beat.
  always_comb begin
    resp_active = ~fifo_empty & ~reset_i;

    mem_resp_header_o = {2{mem_resp_header_i}};
    mem_resp_data_o   = {2{mem_resp_data_i}};

    mem_resp_header_ready_and_o = resp_active & mem_resp_header_ready_and_i[fifo_head];
    mem_resp_data_ready_and_o   = resp_active & mem_resp_data_ready_and_i[fifo_head];

    mem_resp_header_v_o = '0;
    mem_resp_has_data_o = '0;
    mem_resp_data_v_o   = '0;
    mem_resp_last_o     = '0;
    for (int i = 0; i < num_src_lp; i++) begin
      mem_resp_header_v_o[i] = resp_active & (fifo_head == src_id_t'(i)) & mem_resp_header_v_i;
      mem_resp_has_data_o[i] = resp_active & (fifo_head == src_id_t'(i)) & mem_resp_has_data_i;
      mem_resp_data_v_o[i]   = resp_active & (fifo_head == src_id_t'(i)) & mem_resp_data_v_i;
      mem_resp_last_o[i]     = resp_active & (fifo_head == src_id_t'(i)) & mem_resp_last_i;
    end

    fifo_pop = (mem_resp_header_v_i & mem_resp_header_ready_and_o & ~mem_resp_has_data_i)
             | (mem_resp_data_v_i & mem_resp_data_ready_and_o & mem_resp_last_i);
  end

  // Occupancy is only needed as full/empty here; the count stays visible in
  // the FIFO for debug.
  bp_lite_mem_tag_fifo #(.outstanding_p(outstanding_p)) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (hdr_fire),
    .data_i  (cur_src),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

`ifdef BP_LITE_MEM_ARB_STATS_EN
  logic [1:0] stat_issue, stat_stall;

  // A stall is any cycle a source holds header valid without completing it.
  always_comb begin
    stat_issue = '0;
    stat_stall = '0;
    for (int i = 0; i < num_src_lp; i++) begin
      stat_issue[i] = hdr_fire & (cur_src == src_id_t'(i));
      stat_stall[i] = mem_cmd_header_v_i[i] & ~stat_issue[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_cmd_o   <= '0;
      stat_stall_o <= '0;
    end else begin
      for (int i = 0; i < num_src_lp; i++) begin
        if (stat_issue[i] && (stat_cmd_o[i] != '1))   stat_cmd_o[i]   <= stat_cmd_o[i] + 32'd1;
        if (stat_stall[i] && (stat_stall_o[i] != '1)) stat_stall_o[i] <= stat_stall_o[i] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_lite_mem_arbiter.sv
// tb_bp_lite_mem_arbiter
// Self-checking bench for bp_lite_mem_arbiter. Expected grants come from a
// round-robin preference variable and expected response routing from a queue
// of issued source ids, with randomized payloads and backpressure.
module tb_bp_lite_mem_arbiter;

  localparam int HW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef logic [HW-1:0] hw_t;
  typedef logic [DW-1:0] dw_t;

  logic clk_i = 1'b0;
  logic reset_i;

  logic [2*HW-1:0] mem_cmd_header_i;
  logic [1:0]      mem_cmd_header_v_i;
  logic [1:0]      mem_cmd_header_ready_and_o;
  logic [1:0]      mem_cmd_has_data_i;
  logic [2*DW-1:0] mem_cmd_data_i;
  logic [1:0]      mem_cmd_data_v_i;
  logic [1:0]      mem_cmd_data_ready_and_o;
  logic [1:0]      mem_cmd_last_i;
  logic [HW-1:0]   mem_cmd_header_o;
  logic            mem_cmd_header_v_o;
  logic            mem_cmd_header_ready_and_i;
  logic            mem_cmd_has_data_o;
  logic [DW-1:0]   mem_cmd_data_o;
  logic            mem_cmd_data_v_o;
  logic            mem_cmd_data_ready_and_i;
  logic            mem_cmd_last_o;
  logic [HW-1:0]   mem_resp_header_i;
  logic            mem_resp_header_v_i;
  logic            mem_resp_header_ready_and_o;
  logic            mem_resp_has_data_i;
  logic [DW-1:0]   mem_resp_data_i;
  logic            mem_resp_data_v_i;
  logic            mem_resp_data_ready_and_o;
  logic            mem_resp_last_i;
  logic [2*HW-1:0] mem_resp_header_o;
  logic [1:0]      mem_resp_header_v_o;
  logic [1:0]      mem_resp_header_ready_and_i;
  logic [1:0]      mem_resp_has_data_o;
  logic [2*DW-1:0] mem_resp_data_o;
  logic [1:0]      mem_resp_data_v_o;
  logic [1:0]      mem_resp_data_ready_and_i;
  logic [1:0]      mem_resp_last_o;

  int n_compared = 0;
  int n_mismatched = 0;
  int exp_q[$];

  always #5 clk_i = ~clk_i;

  bp_lite_mem_arbiter #(.header_width_p(HW), .data_width_p(DW), .outstanding_p(DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_header_i(mem_cmd_header_i), .mem_cmd_header_v_i(mem_cmd_header_v_i),
    .mem_cmd_header_ready_and_o(mem_cmd_header_ready_and_o), .mem_cmd_has_data_i(mem_cmd_has_data_i),
    .mem_cmd_data_i(mem_cmd_data_i), .mem_cmd_data_v_i(mem_cmd_data_v_i),
    .mem_cmd_data_ready_and_o(mem_cmd_data_ready_and_o), .mem_cmd_last_i(mem_cmd_last_i),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o),
    .mem_cmd_header_ready_and_i(mem_cmd_header_ready_and_i), .mem_cmd_has_data_o(mem_cmd_has_data_o),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
    .mem_cmd_data_ready_and_i(mem_cmd_data_ready_and_i), .mem_cmd_last_o(mem_cmd_last_o),
    .mem_resp_header_i(mem_resp_header_i), .mem_resp_header_v_i(mem_resp_header_v_i),
    .mem_resp_header_ready_and_o(mem_resp_header_ready_and_o), .mem_resp_has_data_i(mem_resp_has_data_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
    .mem_resp_data_ready_and_o(mem_resp_data_ready_and_o), .mem_resp_last_i(mem_resp_last_i),
    .mem_resp_header_o(mem_resp_header_o), .mem_resp_header_v_o(mem_resp_header_v_o),
    .mem_resp_header_ready_and_i(mem_resp_header_ready_and_i), .mem_resp_has_data_o(mem_resp_has_data_o),
    .mem_resp_data_o(mem_resp_data_o), .mem_resp_data_v_o(mem_resp_data_v_o),
    .mem_resp_data_ready_and_i(mem_resp_data_ready_and_i), .mem_resp_last_o(mem_resp_last_o)
  );

  task automatic clear_inputs();
    mem_cmd_header_i = '0; mem_cmd_header_v_i = '0; mem_cmd_has_data_i = '0;
    mem_cmd_data_i = '0; mem_cmd_data_v_i = '0; mem_cmd_last_i = '0;
    mem_cmd_header_ready_and_i = 1'b0; mem_cmd_data_ready_and_i = 1'b0;
    mem_resp_header_i = '0; mem_resp_header_v_i = 1'b0; mem_resp_has_data_i = 1'b0;
    mem_resp_data_i = '0; mem_resp_data_v_i = 1'b0; mem_resp_last_i = 1'b0;
    mem_resp_header_ready_and_i = '0; mem_resp_data_ready_and_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    clear_inputs();
    exp_q.delete();
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    mem_cmd_header_i = {hw_t'($urandom), hw_t'($urandom)};
    mem_cmd_header_v_i = 2'b11;
    mem_cmd_header_ready_and_i = 1'b1;
    mem_cmd_data_ready_and_i = 1'b1;
    mem_cmd_data_v_i = 2'b11;
    mem_resp_header_v_i = 1'b1;
    mem_resp_header_ready_and_i = 2'b11;
    mem_resp_data_ready_and_i = 2'b11;
    #1;
    n_compared++;
    if (mem_cmd_header_ready_and_o !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL reset_first_grant: got %b want 01", mem_cmd_header_ready_and_o);
    end
    reset_i = 1'b1;
    #1;
    n_compared++;
    if (mem_cmd_header_v_o !== 1'b0 || mem_cmd_header_ready_and_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_cmd_hdr: got v=%b rdy=%b want 0/00", mem_cmd_header_v_o, mem_cmd_header_ready_and_o);
    end
    n_compared++;
    if (mem_cmd_data_v_o !== 1'b0 || mem_cmd_data_ready_and_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_cmd_data: got v=%b rdy=%b want 0/00", mem_cmd_data_v_o, mem_cmd_data_ready_and_o);
    end
    n_compared++;
    if (mem_resp_header_ready_and_o !== 1'b0 || mem_resp_data_ready_and_o !== 1'b0 || mem_resp_header_v_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_resp: got hrdy=%b drdy=%b v=%b want 0/0/00",
               mem_resp_header_ready_and_o, mem_resp_data_ready_and_o, mem_resp_header_v_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    n_compared++;
    if (mem_cmd_header_v_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_held: got v=%b want 0", mem_cmd_header_v_o);
    end
    clear_inputs();
    reset_i = 1'b0;
  endtask

  task automatic test_single_read();
    hw_t h0, rh;
    dw_t d1, d2;
    do_reset();
    h0 = hw_t'($urandom); rh = hw_t'($urandom); d1 = dw_t'($urandom); d2 = dw_t'($urandom);
    mem_cmd_header_i[HW-1:0] = h0;
    mem_cmd_header_v_i = 2'b01;
    mem_cmd_header_ready_and_i = 1'b1;
    #1;
    n_compared++;
    if (mem_cmd_header_v_o !== 1'b1 || mem_cmd_header_o !== h0 || mem_cmd_has_data_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL read_hdr_fwd: got v=%b h=%h hd=%b want 1/%h/0", mem_cmd_header_v_o, mem_cmd_header_o, mem_cmd_has_data_o, h0);
    end
    n_compared++;
    if (mem_cmd_header_ready_and_o !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL read_hdr_rdy: got %b want 01", mem_cmd_header_ready_and_o);
    end
    step();
    mem_cmd_header_v_i = 2'b00;
    mem_resp_header_i = rh; mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = 1'b1;
    mem_resp_header_ready_and_i = 2'b01;
    #1;
    n_compared++;
    if (mem_resp_header_v_o !== 2'b01 || mem_resp_header_o[HW-1:0] !== rh || mem_resp_header_ready_and_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL read_resp_hdr: got v=%b h=%h rdy=%b want 01/%h/1", mem_resp_header_v_o, mem_resp_header_o[HW-1:0], mem_resp_header_ready_and_o, rh);
    end
    step();
    mem_resp_header_v_i = 1'b0;
    mem_resp_data_i = d1; mem_resp_data_v_i = 1'b1; mem_resp_last_i = 1'b0;
    mem_resp_data_ready_and_i = 2'b01;
    #1;
    n_compared++;
    if (mem_resp_data_v_o !== 2'b01 || mem_resp_data_o[DW-1:0] !== d1 || mem_resp_data_ready_and_o !== 1'b1 || mem_resp_last_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL read_beat1: got v=%b d=%h rdy=%b last=%b want 01/%h/1/00", mem_resp_data_v_o, mem_resp_data_o[DW-1:0], mem_resp_data_ready_and_o, mem_resp_last_o, d1);
    end
    step();
    mem_resp_data_i = d2; mem_resp_last_i = 1'b1;
    #1;
    n_compared++;
    if (mem_resp_data_v_o !== 2'b01 || mem_resp_data_o[DW-1:0] !== d2 || mem_resp_last_o !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL read_beat2: got v=%b d=%h last=%b want 01/%h/01", mem_resp_data_v_o, mem_resp_data_o[DW-1:0], mem_resp_last_o, d2);
    end
    step();
    mem_resp_data_v_i = 1'b0; mem_resp_last_i = 1'b0;
    mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = 1'b0;
    mem_resp_header_ready_and_i = 2'b11;
    #1;
    n_compared++;
    if (mem_resp_header_ready_and_o !== 1'b0 || mem_resp_header_v_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL read_drained: got rdy=%b v=%b want 0/00", mem_resp_header_ready_and_o, mem_resp_header_v_o);
    end
    clear_inputs();
  endtask

  task automatic test_contention_full();
    hw_t h [2];
    int pref, exp_src;
    logic [1:0] want;
    do_reset();
    pref = 0;
    mem_cmd_header_v_i = 2'b11;
    mem_cmd_header_ready_and_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      h[0] = hw_t'($urandom); h[1] = hw_t'($urandom);
      mem_cmd_header_i = {h[1], h[0]};
      #1;
      exp_src = pref;
      want = 2'b01 << exp_src;
      n_compared++;
      if (mem_cmd_header_ready_and_o !== want || mem_cmd_header_o !== h[exp_src]) begin
        n_mismatched++;
        $display("[TB] FAIL contention_grant%0d: got rdy=%b h=%h want %b/%h", k, mem_cmd_header_ready_and_o, mem_cmd_header_o, want, h[exp_src]);
      end
      exp_q.push_back(exp_src);
      pref = 1 - exp_src;
      step();
    end
    #1;
    n_compared++;
    if (mem_cmd_header_v_o !== 1'b0 || mem_cmd_header_ready_and_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL full_stall: got v=%b rdy=%b want 0/00", mem_cmd_header_v_o, mem_cmd_header_ready_and_o);
    end
    step();
    mem_resp_header_v_i = 1'b1; mem_resp_has_data_i = 1'b0;
    mem_resp_header_i = hw_t'($urandom);
    mem_resp_header_ready_and_i = 2'b11;
    #1;
    want = 2'b01 << exp_q[0];
    n_compared++;
    if (mem_resp_header_v_o !== want || mem_cmd_header_v_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_pop_cycle: got resp_v=%b cmd_v=%b want %b/0", mem_resp_header_v_o, mem_cmd_header_v_o, want);
    end
    step();
    void'(exp_q.pop_front());
    mem_resp_header_v_i = 1'b0;
    #1;
    want = 2'b01 << pref;
    n_compared++;
    if (mem_cmd_header_v_o !== 1'b1 || mem_cmd_header_ready_and_o !== want) begin
      n_mismatched++;
      $display("[TB] FAIL full_release: got v=%b rdy=%b want 1/%b", mem_cmd_header_v_o, mem_cmd_header_ready_and_o, want);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_locked_write();
    hw_t h0, h1;
    dw_t beats [4];
    int beat, cyc;
    logic rdy;
    do_reset();
    h0 = hw_t'($urandom); h1 = hw_t'($urandom);
    for (int i = 0; i < 4; i++) beats[i] = dw_t'($urandom);
    mem_cmd_header_i = {h1, h0};
    mem_cmd_header_v_i = 2'b10;
    mem_cmd_has_data_i = 2'b10;
    mem_cmd_header_ready_and_i = 1'b1;
    #1;
    n_compared++;
    if (mem_cmd_header_ready_and_o !== 2'b10 || mem_cmd_has_data_o !== 1'b1 || mem_cmd_header_o !== h1) begin
      n_mismatched++;
      $display("[TB] FAIL write_hdr: got rdy=%b hd=%b h=%h want 10/1/%h", mem_cmd_header_ready_and_o, mem_cmd_has_data_o, mem_cmd_header_o, h1);
    end
    step();
    mem_cmd_header_v_i = 2'b01;
    mem_cmd_data_v_i = 2'b11;
    beat = 0;
    cyc = 0;
    while (beat < 4 && cyc < 40) begin
      mem_cmd_data_i = {beats[beat], dw_t'($urandom)};
      mem_cmd_last_i = {(beat == 3), 1'b1};
      rdy = (cyc >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_cmd_data_ready_and_i = rdy;
      #1;
      n_compared++;
      if (mem_cmd_header_v_o !== 1'b0 || mem_cmd_data_v_o !== 1'b1 || mem_cmd_data_o !== beats[beat]
          || mem_cmd_last_o !== (beat == 3) || mem_cmd_data_ready_and_o !== {rdy, 1'b0}) begin
        n_mismatched++;
        $display("[TB] FAIL write_beat%0d: got hv=%b dv=%b d=%h last=%b rdy=%b want 0/1/%h/%b/%b",
                 beat, mem_cmd_header_v_o, mem_cmd_data_v_o, mem_cmd_data_o, mem_cmd_last_o,
                 mem_cmd_data_ready_and_o, beats[beat], (beat == 3), {rdy, 1'b0});
      end
      step();
      if (rdy) beat++;
      cyc++;
    end
    n_compared++;
    if (beat != 4) begin
      n_mismatched++;
      $display("[TB] FAIL write_timeout: got %0d beats want 4", beat);
    end
    mem_cmd_data_v_i = 2'b00;
    mem_cmd_last_i = 2'b00;
    #1;
    n_compared++;
    if (mem_cmd_header_v_o !== 1'b1 || mem_cmd_header_ready_and_o !== 2'b01 || mem_cmd_header_o !== h0) begin
      n_mismatched++;
      $display("[TB] FAIL write_then_icache: got v=%b rdy=%b h=%h want 1/01/%h", mem_cmd_header_v_o, mem_cmd_header_ready_and_o, mem_cmd_header_o, h0);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_response_steering();
    int order [3];
    int d, nb, cyc;
    logic done, first_bp;
    logic [1:0] rdy, want;
    hw_t rh;
    dw_t rd;
    order = '{1, 0, 1};
    do_reset();
    mem_cmd_header_ready_and_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_cmd_header_v_i = 2'b00;
      mem_cmd_header_v_i[order[k]] = 1'b1;
      #1;
      want = 2'b01 << order[k];
      n_compared++;
      if (mem_cmd_header_ready_and_o !== want) begin
        n_mismatched++;
        $display("[TB] FAIL steer_issue%0d: got %b want %b", k, mem_cmd_header_ready_and_o, want);
      end
      exp_q.push_back(order[k]);
      step();
    end
    mem_cmd_header_v_i = 2'b00;
    first_bp = 1'b1;
    for (int r = 0; r < 3; r++) begin
      d = exp_q.pop_front();
      want = 2'b01 << d;
      nb = $urandom_range(0, 3);
      rh = hw_t'($urandom);
      mem_resp_header_i = rh;
      mem_resp_has_data_i = (nb != 0);
      mem_resp_header_v_i = 1'b1;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 30) begin
        rdy = (cyc >= 20) ? 2'b11 : 2'($urandom_range(0, 3));
        if (d == 0 && first_bp) begin
          rdy[0] = 1'b0;
          first_bp = 1'b0;
        end
        mem_resp_header_ready_and_i = rdy;
        #1;
        n_compared++;
        if (mem_resp_header_v_o !== want || mem_resp_header_ready_and_o !== rdy[d] || mem_resp_header_o[d*HW +: HW] !== rh) begin
          n_mismatched++;
          $display("[TB] FAIL steer_hdr%0d: got v=%b rdy=%b h=%h want %b/%b/%h", r, mem_resp_header_v_o,
                   mem_resp_header_ready_and_o, mem_resp_header_o[d*HW +: HW], want, rdy[d], rh);
        end
        step();
        done = rdy[d];
        cyc++;
      end
      mem_resp_header_v_i = 1'b0;
      for (int b = 0; b < nb; b++) begin
        rd = dw_t'($urandom);
        mem_resp_data_i = rd;
        mem_resp_data_v_i = 1'b1;
        mem_resp_last_i = (b == nb - 1);
        done = 1'b0;
        while (!done && cyc < 60) begin
          rdy = (cyc >= 40) ? 2'b11 : 2'($urandom_range(0, 3));
          mem_resp_data_ready_and_i = rdy;
          #1;
          n_compared++;
          if (mem_resp_data_v_o !== want || mem_resp_data_ready_and_o !== rdy[d] || mem_resp_data_o[d*DW +: DW] !== rd) begin
            n_mismatched++;
            $display("[TB] FAIL steer_data%0d_%0d: got v=%b rdy=%b d=%h want %b/%b/%h", r, b, mem_resp_data_v_o,
                     mem_resp_data_ready_and_o, mem_resp_data_o[d*DW +: DW], want, rdy[d], rd);
          end
          step();
          done = rdy[d];
          cyc++;
        end
      end
      mem_resp_data_v_i = 1'b0;
      mem_resp_last_i = 1'b0;
      n_compared++;
      if (!done) begin
        n_mismatched++;
        $display("[TB] FAIL steer_timeout%0d: got incomplete want complete", r);
      end
    end
    mem_resp_header_v_i = 1'b1;
    mem_resp_header_ready_and_i = 2'b11;
    #1;
    n_compared++;
    if (mem_resp_header_ready_and_o !== 1'b0 || mem_resp_header_v_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL steer_empty: got rdy=%b v=%b want 0/00", mem_resp_header_ready_and_o, mem_resp_header_v_o);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_data();
    hw_t h0;
    do_reset();
    h0 = hw_t'($urandom);
    mem_cmd_header_i = {hw_t'($urandom), h0};
    mem_cmd_header_v_i = 2'b10;
    mem_cmd_has_data_i = 2'b10;
    mem_cmd_header_ready_and_i = 1'b1;
    mem_cmd_data_ready_and_i = 1'b1;
    step();
    mem_cmd_data_i = {dw_t'($urandom), dw_t'($urandom)};
    mem_cmd_data_v_i = 2'b10;
    mem_cmd_last_i = 2'b00;
    step();
    mem_cmd_header_v_i = 2'b11;
    mem_cmd_data_i = {dw_t'($urandom), dw_t'($urandom)};
    #1;
    n_compared++;
    if (mem_cmd_data_v_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_beat2_live: got %b want 1", mem_cmd_data_v_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    n_compared++;
    if (mem_cmd_data_v_o !== 1'b0 || mem_cmd_data_ready_and_o !== 2'b00
        || mem_cmd_header_v_o !== 1'b0 || mem_cmd_header_ready_and_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_async: got dv=%b drdy=%b hv=%b hrdy=%b want 0/00/0/00",
               mem_cmd_data_v_o, mem_cmd_data_ready_and_o, mem_cmd_header_v_o, mem_cmd_header_ready_and_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    mem_cmd_data_v_i = 2'b00;
    mem_resp_header_v_i = 1'b1;
    mem_resp_header_ready_and_i = 2'b11;
    #1;
    n_compared++;
    if (mem_cmd_header_ready_and_o !== 2'b01 || mem_cmd_header_o !== h0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_regrant: got rdy=%b h=%h want 01/%h", mem_cmd_header_ready_and_o, mem_cmd_header_o, h0);
    end
    n_compared++;
    if (mem_resp_header_ready_and_o !== 1'b0 || mem_resp_header_v_o !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_fifo_empty: got rdy=%b v=%b want 0/00", mem_resp_header_ready_and_o, mem_resp_header_v_o);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    test_reset();
    test_single_read();
    test_contention_full();
    test_locked_write();
    test_response_steering();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
